// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl
//   Attempt scheduler for the fault-injection datapath. Each attempt pulses
//   the target reset, waits a programmable delay after release, fires a glitch
//   pulse of programmable width, then watches the debug byte for a verdict.
//   Failed or timed-out attempts step a 2-D (delay inner, width outer) sweep
//   and re-arm; the sweep stops on the success code, abort, or exhaustion.
//
// Ports
//   CLK          system clock
//   RST          synchronous active-high reset
//   start        level, accepted in IDLE/DONE; begins a sweep at (DELAY_MIN, WIDTH_MIN)
//   abort        level, returns to IDLE from any state (beats start)
//   debug_in     synchronized debug GPIO byte
//   nrst_out     target reset, active low
//   glitch_out   glitch MOSFET drive, active high
//   busy         high outside IDLE/DONE
//   result_valid one-cycle pulse at the end of each attempt
//   result_pass  verdict of the last attempt
//   success      sticky in DONE: 1 = success code seen, 0 = sweep exhausted
//   cur_delay    delay of current/last attempt
//   cur_width    width of current/last attempt
//   attempt_cnt  attempts started since start, saturating
module glitch_sweep_ctrl #(
    parameter logic [15:0] RESET_LEN    = 16'h0010,
    parameter logic [15:0] DELAY_MIN    = 16'h0001,
    parameter logic [15:0] DELAY_MAX    = 16'h0300,
    parameter logic [15:0] WIDTH_MIN    = 16'h0180,
    parameter logic [15:0] WIDTH_MAX    = 16'h0181,
    parameter logic [23:0] TIMEOUT      = 24'h100000,
    parameter logic [7:0]  SUCCESS_CODE = 8'h88,
    parameter logic [7:0]  FAIL_CODE    = 8'hC3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  debug_in,
    output logic        nrst_out,
    output logic        glitch_out,
    output logic        busy,
    output logic        result_valid,
    output logic        result_pass,
    output logic        success,
    output logic [15:0] cur_delay,
    output logic [15:0] cur_width,
    output logic [23:0] attempt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_DELAY, S_GLITCH, S_WATCH, S_NEXT, S_DONE
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;        // RESET / DELAY / GLITCH down-counter
    logic [23:0] wcnt_q;       // WATCH down-counter
    logic        nrst_q, glitch_q, busy_q, rv_q, pass_q, succ_q;
    logic [15:0] delay_q, width_q;
    logic [23:0] attempt_q;

    // Next sweep point and saturating attempt increment
    logic [15:0] step_delay_d, step_width_d;
    logic        sweep_end_d;
    logic [23:0] attempt_inc_d;
    logic        dbg_pass_d, dbg_fail_d;

    always_comb begin
        step_delay_d = delay_q;
        step_width_d = width_q;
        sweep_end_d  = 1'b0;
        if (delay_q < DELAY_MAX) begin
            step_delay_d = delay_q + 16'd1;
        end else if (width_q < WIDTH_MAX) begin
            step_delay_d = DELAY_MIN;
            step_width_d = width_q + 16'd1;
        end else begin
            sweep_end_d = 1'b1;
        end
        attempt_inc_d = (attempt_q == 24'hFFFFFF) ? attempt_q : attempt_q + 24'd1;
        dbg_pass_d    = (debug_in == SUCCESS_CODE);
        dbg_fail_d    = (debug_in == FAIL_CODE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            nrst_q    <= 1'b1;
            glitch_q  <= 1'b0;
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
            pass_q    <= 1'b0;
            succ_q    <= 1'b0;
            delay_q   <= DELAY_MIN;
            width_q   <= WIDTH_MIN;
            attempt_q <= '0;
        end else begin
            rv_q <= 1'b0;
            if (abort) begin
                // Abort touches only state and pin/status outputs; sweep
                // position and attempt count survive for inspection.
                state_q  <= S_IDLE;
                nrst_q   <= 1'b1;
                glitch_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            delay_q   <= DELAY_MIN;
                            width_q   <= WIDTH_MIN;
                            attempt_q <= 24'd1;   // cleared, then counted on RESET entry
                            succ_q    <= 1'b0;
                            state_q   <= S_RESET;
                            nrst_q    <= 1'b0;
                            glitch_q  <= 1'b0;
                            busy_q    <= 1'b1;
                            cnt_q     <= RESET_LEN - 16'd1;
                        end
                    end
                    S_RESET: begin
                        if (cnt_q == 16'd0) begin
                            nrst_q <= 1'b1;
                            if (delay_q == 16'd0) begin
                                state_q  <= S_GLITCH;
                                glitch_q <= 1'b1;
                                cnt_q    <= width_q - 16'd1;
                            end else begin
                                state_q <= S_DELAY;
                                cnt_q   <= delay_q - 16'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    S_DELAY: begin
                        if (cnt_q == 16'd0) begin
                            state_q  <= S_GLITCH;
                            glitch_q <= 1'b1;
                            cnt_q    <= width_q - 16'd1;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    S_GLITCH: begin
                        if (cnt_q == 16'd0) begin
                            state_q  <= S_WATCH;
                            glitch_q <= 1'b0;
                            wcnt_q   <= TIMEOUT - 24'd1;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    S_WATCH: begin
                        // Success is checked first so it wins over fail/timeout.
                        if (dbg_pass_d) begin
                            rv_q    <= 1'b1;
                            pass_q  <= 1'b1;
                            succ_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else if (dbg_fail_d || wcnt_q == 24'd0) begin
                            rv_q    <= 1'b1;
                            pass_q  <= 1'b0;
                            state_q <= S_NEXT;
                        end else begin
                            wcnt_q <= wcnt_q - 24'd1;
                        end
                    end
                    S_NEXT: begin
                        delay_q <= step_delay_d;
                        width_q <= step_width_d;
                        if (sweep_end_d) begin
                            succ_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            state_q   <= S_RESET;
                            nrst_q    <= 1'b0;
                            cnt_q     <= RESET_LEN - 16'd1;
                            attempt_q <= attempt_inc_d;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        nrst_q   <= 1'b1;
                        glitch_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign nrst_out     = nrst_q;
    assign glitch_out   = glitch_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign result_pass  = pass_q;
    assign success      = succ_q;
    assign cur_delay    = delay_q;
    assign cur_width    = width_q;
    assign attempt_cnt  = attempt_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Bench for glitch_sweep_ctrl: a cycle table for basic timing and priority,
// hand sequences for success/early-fail/abort/reset, and random debug
// traffic checked against a trace built directly from the attempt timeline.
module tb_glitch_sweep_ctrl;

    localparam int RL   = 4;
    localparam int DMIN = 2;
    localparam int DMAX = 3;
    localparam int WMIN = 1;
    localparam int WMAX = 2;
    localparam int TO   = 10;

    logic        CLK = 1'b0;
    logic        RST, start, abort;
    logic [7:0]  debug_in;
    logic        nrst_out, glitch_out, busy, result_valid, result_pass, success;
    logic [15:0] cur_delay, cur_width;
    logic [23:0] attempt_cnt;

    always #5 CLK = ~CLK;

    glitch_sweep_ctrl #(
        .RESET_LEN(16'(RL)), .DELAY_MIN(16'(DMIN)), .DELAY_MAX(16'(DMAX)),
        .WIDTH_MIN(16'(WMIN)), .WIDTH_MAX(16'(WMAX)), .TIMEOUT(24'(TO)),
        .SUCCESS_CODE(8'h88), .FAIL_CODE(8'hC3)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .debug_in(debug_in),
        .nrst_out(nrst_out), .glitch_out(glitch_out), .busy(busy),
        .result_valid(result_valid), .result_pass(result_pass), .success(success),
        .cur_delay(cur_delay), .cur_width(cur_width), .attempt_cnt(attempt_cnt)
    );

    typedef struct packed {
        logic        nrst, glitch, busy, rv, pass, succ;
        logic [15:0] d, w;
        logic [23:0] n;
    } obs_t;

    typedef struct {
        logic       st, ab;
        logic [7:0] dbg;
        obs_t       exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic obs_t observe();
        obs_t o;
        o = {nrst_out, glitch_out, busy, result_valid, result_pass, success,
             cur_delay, cur_width, attempt_cnt};
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o.nrst = 1'b1; o.glitch = 1'b0; o.busy = 1'b0; o.rv = 1'b0;
        o.pass = 1'b0; o.succ = 1'b0;
        o.d = 16'(DMIN); o.w = 16'(WMIN); o.n = 24'd0;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1; start = 1'b0; abort = 1'b0; debug_in = 8'h00;
        tick();
        RST = 1'b0;
    endtask

    // Random debug traffic over a whole sweep; expected trace is laid out
    // attempt by attempt from the timeline (reset, delay, pulse, watch).
    task automatic run_random(input int id);
        obs_t       ex[128];
        logic [7:0] dbg[128];
        obs_t       o;
        int         c, n, r, last;
        bit         fin;
        for (int k = 0; k < 128; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)      dbg[k] = 8'h88;
            else if (r < 8) dbg[k] = 8'hC3;
            else            dbg[k] = 8'($urandom);
        end
        o = reset_obs();
        c = 0; n = 0; fin = 1'b0;
        for (int w = WMIN; w <= WMAX; w++) begin
            for (int d = DMIN; d <= DMAX; d++) begin
                if (!fin) begin
                    n++;
                    o.d = 16'(d); o.w = 16'(w); o.n = 24'(n);
                    o.busy = 1'b1; o.rv = 1'b0; o.nrst = 1'b0; o.glitch = 1'b0;
                    repeat (RL) begin ex[c] = o; c++; end
                    o.nrst = 1'b1;
                    repeat (d) begin ex[c] = o; c++; end
                    o.glitch = 1'b1;
                    repeat (w) begin ex[c] = o; c++; end
                    o.glitch = 1'b0;
                    ex[c] = o; c++;
                    for (int j = 1; j <= TO; j++) begin
                        if (dbg[c] == 8'h88) begin
                            o.rv = 1'b1; o.pass = 1'b1; o.succ = 1'b1; o.busy = 1'b0;
                            ex[c] = o; c++; fin = 1'b1;
                            break;
                        end else if (dbg[c] == 8'hC3 || j == TO) begin
                            o.rv = 1'b1; o.pass = 1'b0;
                            ex[c] = o; c++;
                            break;
                        end else begin
                            ex[c] = o; c++;
                        end
                    end
                    o.rv = 1'b0;
                    if (!fin && d == DMAX && w == WMAX) begin
                        o.busy = 1'b0;
                        ex[c] = o; c++; fin = 1'b1;
                    end
                end
            end
        end
        repeat (3) begin ex[c] = o; c++; end
        last = c;

        do_reset();
        for (int k = 0; k < last; k++) begin
            start    = (k == 0);
            debug_in = dbg[k];
            tick();
            chk($sformatf("rand%0d_cyc%0d", id, k), observe(), ex[k]);
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t  tbl[21];
        obs_t  o;
        int    cyc;
        bit    hit;

        RST = 1'b1; start = 1'b0; abort = 1'b0; debug_in = 8'h00;
        @(negedge CLK);

        // ---- cycle table: attempt (2,1) times out, NEXT, then abort and start+abort
        o = reset_obs();
        for (int i = 0; i < 21; i++) begin
            tbl[i].st = (i == 0) || (i == 20);
            tbl[i].ab = (i >= 19);
            tbl[i].dbg = 8'h00;
            tbl[i].exp = o;
            tbl[i].exp.busy = 1'b1;
            tbl[i].exp.n    = 24'd1;
            if (i <= 3)  tbl[i].exp.nrst = 1'b0;
            if (i == 6)  tbl[i].exp.glitch = 1'b1;
            if (i == 17) tbl[i].exp.rv = 1'b1;
            if (i >= 18) begin
                tbl[i].exp.d = 16'd3;
                tbl[i].exp.n = 24'd2;
            end
            if (i == 18) tbl[i].exp.nrst = 1'b0;
            if (i >= 19) tbl[i].exp.busy = 1'b0;
        end

        do_reset();
        chk("reset_state", observe(), reset_obs());
        for (int i = 0; i < 21; i++) begin
            start = tbl[i].st; abort = tbl[i].ab; debug_in = tbl[i].dbg;
            tick();
            chk($sformatf("vec%0d", i), observe(), tbl[i].exp);
        end
        start = 1'b0; abort = 1'b0;

        // ---- success in attempt 2
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (attempt_cnt == 24'd2) debug_in = 8'h88;
            tick();
            if (result_valid && attempt_cnt == 24'd2) hit = 1'b1;
        end
        chk("succ_seen", 64'(hit), 64'd1);
        o = reset_obs();
        o.rv = 1'b1; o.pass = 1'b1; o.succ = 1'b1; o.d = 16'd3; o.n = 24'd2;
        chk("succ_verdict", observe(), o);
        debug_in = 8'h00;
        tick(); tick();
        o.rv = 1'b0;
        chk("succ_sticky", observe(), o);

        // ---- early fail on first WATCH cycle
        do_reset();
        debug_in = 8'hC3;
        start = 1'b1; tick(); start = 1'b0;
        cyc = -1;
        for (int k = 1; k < 40 && cyc < 0; k++) begin
            tick();
            if (result_valid) cyc = k;
        end
        chk("efail_latency", 64'(cyc), 64'd8);
        chk("efail_pass", 64'(result_pass), 64'd0);
        tick();
        chk("efail_next_nrst", 64'(nrst_out), 64'd0);
        chk("efail_next_point", {24'd0, attempt_cnt, cur_delay}, {24'd0, 24'd2, 16'd3});
        debug_in = 8'h00;

        // ---- abort during a 2-cycle glitch pulse
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            tick();
            if (glitch_out && cur_width == 16'd2) hit = 1'b1;
        end
        chk("abort_found_pulse", 64'(hit), 64'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_pins", {61'd0, glitch_out, nrst_out, busy}, {61'd0, 1'b0, 1'b1, 1'b0});
        chk("abort_keep_cnt", 64'(attempt_cnt), 64'd3);
        tick();
        chk("abort_idle", {61'd0, glitch_out, nrst_out, busy}, {61'd0, 1'b0, 1'b1, 1'b0});

        // ---- RST in the middle of RESET
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("mid_reset_low", 64'(nrst_out), 64'd0);
        RST = 1'b1; tick(); RST = 1'b0;
        chk("rst_mid_reset", observe(), reset_obs());

        // ---- randomized sweeps
        for (int r = 0; r < 6; r++) run_random(r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/glitch_sweep_ctrl.md
# glitch_sweep_ctrl

Attempt scheduler for the fault-injection datapath: it sequences target reset, glitch delay and glitch pulse, then watches the debug port for a verdict. Each attempt runs the same fixed sequence: reset pulse, delay from reset release, glitch pulse of programmable width, verdict watch window. On failure or timeout the block advances a 2-D (delay, width) sweep and re-arms. It stops on the success code, on abort, or when the sweep is exhausted. It replaces the ad-hoc button-bounce counters in the top level and drives the reset and glitch MOSFET pins through the existing tri-state assigns.

## Interface
Parameters:
- RESET_LEN, 16'h0010: cycles nrst_out is held low per attempt (≥1)
- DELAY_MIN, 16'h0001: first delay, cycles from reset release to glitch start
- DELAY_MAX, 16'h0300: last delay, inclusive (≥ DELAY_MIN)
- WIDTH_MIN, 16'h0180: first glitch width in cycles (≥1)
- WIDTH_MAX, 16'h0181: last width, inclusive (≥ WIDTH_MIN)
- TIMEOUT, 24'h100000: verdict watch window in cycles (≥1)
- SUCCESS_CODE, 8'h88: debug value meaning success
- FAIL_CODE, 8'hC3: debug value meaning early failure

Ports:
- CLK  in  1  system clock (12 MHz)
- RST  in  1  synchronous, active-high reset
- start  in  1  level; sampled in IDLE/DONE, begins a sweep from (DELAY_MIN, WIDTH_MIN)
- abort  in  1  level; returns to IDLE from any state
- debug_in  in  8  debug GPIO byte, already synchronized upstream
- nrst_out  out  1  target reset, active low
- glitch_out  out  1  glitch MOSFET drive, active high
- busy  out  1  high in any state except IDLE/DONE
- result_valid  out  1  one-cycle pulse at end of each attempt
- result_pass  out  1  verdict of the attempt; valid with result_valid
- success  out  1  sticky in DONE: 1 = success code seen, 0 = sweep exhausted
- cur_delay  out  16  delay of the current/last attempt
- cur_width  out  16  width of the current/last attempt
- attempt_cnt  out  24  attempts started since start; saturates at 24'hFFFFFF

## Operation
- States: IDLE, RESET, DELAY, GLITCH, WATCH, NEXT, DONE. All outputs are registered.
- RST (and abort, which has the same effect except it clears nothing but state and outputs):
  - state = IDLE; nrst_out = 1; glitch_out = 0; busy = 0; result_valid = 0.
  - RST only: success = 0, cur_delay = DELAY_MIN, cur_width = WIDTH_MIN, attempt_cnt = 0.
  - abort leaves cur_delay, cur_width and attempt_cnt unchanged.
- IDLE/DONE + start:
  - Load cur_delay = DELAY_MIN, cur_width = WIDTH_MIN.
  - Clear attempt_cnt and success.
  - Enter RESET.
- RESET:
  - nrst_out = 0 for exactly RESET_LEN cycles.
  - attempt_cnt increments on entry.
  - Then go to DELAY.
- DELAY:
  - nrst_out = 1, glitch_out = 0 for cur_delay cycles.
  - If cur_delay = 0, skip straight to GLITCH.
- GLITCH: glitch_out = 1 for cur_width cycles, then WATCH.
- WATCH:
  - Counts up to TIMEOUT cycles.
  - debug_in == SUCCESS_CODE → result_valid = 1, result_pass = 1, success = 1, enter DONE.
  - debug_in == FAIL_CODE, or TIMEOUT expires → result_valid = 1, result_pass = 0, enter NEXT.
  - If both conditions hit in the same cycle, success takes priority.
- NEXT (one cycle):
  - If cur_delay < DELAY_MAX: cur_delay + 1.
  - Else if cur_width < WIDTH_MAX: cur_delay = DELAY_MIN and cur_width + 1.
  - If the step succeeded, go to RESET.
  - If both are at max: success = 0, enter DONE, cur_* hold the final point.
- DONE:
  - nrst_out = 1, glitch_out = 0.
  - Holds until start or abort.
- Abort beats start when both are asserted in the same cycle.

## Timing
- Start accepted at edge 0: nrst_out low at edges 1..RESET_LEN.
- Then nrst_out rises at edge RESET_LEN+1 (call it R); glitch_out is high at edges R+cur_delay .. R+cur_delay+cur_width-1.
- WATCH begins the cycle glitch_out falls; a matching debug_in sampled at edge t gives result_valid at edge t+1.
- TIMEOUT expiry: result_valid at the TIMEOUT-th WATCH cycle.
- NEXT costs 1 cycle; the next RESET starts the cycle after NEXT.
- abort/RST sampled at edge t: outputs at their IDLE values from edge t+1.
- Counters: 16-bit for delay/width and 24-bit for watch, all counting down; arithmetic is unsigned with no wrap.

## Test plan
Bench parameters for all scenarios: RESET_LEN=4, DELAY_MIN=2, DELAY_MAX=3, WIDTH_MIN=1, WIDTH_MAX=2, TIMEOUT=10.

- **Basic timing:** start with debug_in held at 8'h00 → nrst_out low for exactly 4 cycles; glitch_out high 2 cycles after release, for 1 cycle; result_valid with result_pass=0 after 10 watch cycles.
- **Sweep order:** never assert success → attempts run (2,1), (3,1), (2,2), (3,2); attempt_cnt=4; DONE with success=0 and cur_delay=3, cur_width=2.
- **Success:** drive 8'h88 in WATCH of attempt 2 → result_pass=1, success=1, busy=0; sweep halts with cur_delay=3, cur_width=1.
- **Early fail:** drive 8'hC3 on the first WATCH cycle → NEXT entered immediately, with no timeout wait.
- **Abort mid-pulse:** assert abort during GLITCH → next cycle glitch_out=0, nrst_out=1, state IDLE; attempt_cnt is retained.
- **Reset and priority:** assert RST mid-RESET → all outputs at their reset values one cycle later. Assert start and abort together → block stays in IDLE.
